loop_stack_unit: RTL and testbench
==================================

LOOP_STACK_UNIT -- requirements
Module: loop_stack_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, maximum number of open loops held in the return stack (DEPTH >= 2).
REQ-003 SHALL have parameter NEST_W, default 8, width of the skip-nesting counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-005 SHALL have port instr_valid  in  1  instruction presented this cycle.
REQ-006 SHALL have port is_open  in  1  presented instruction is '['.
REQ-007 SHALL have port is_close  in  1  presented instruction is ']'.
REQ-008 SHALL have port pc  in  PC_W  address of the presented instruction.
REQ-009 SHALL have port acc_zero  in  1  accumulator equals zero.
REQ-010 SHALL have port clear  in  1  synchronous flush of stack and mode.
REQ-011 SHALL have port pc_load  out  1  redirect fetch to pc_target next edge.
REQ-012 SHALL have port pc_target  out  PC_W  redirect address.
REQ-013 SHALL have port squash  out  1  presented instruction must not execute.
REQ-014 SHALL have port depth  out  $clog2(DEPTH+1)  current stack occupancy.
REQ-015 SHALL have port fault  out  1  unit in FAULT state.

Function
REQ-016 SHALL implement states RUN, SKIP, FAULT; state, stack, depth and nest counter update only on rising clk edges with instr_valid or clear high.
REQ-017 SHALL drive pc_load, pc_target and squash combinationally from the current inputs and registered state, in the same cycle as the instruction (zero latency).
REQ-018 RUN, '[' with acc_zero=0: SHALL push pc, depth+1, no redirect, squash=0.
REQ-019 RUN, '[' with acc_zero=1: SHALL enter SKIP with nest=0, no push, squash=1.
REQ-020 RUN, ']' with acc_zero=0: SHALL assert pc_load with pc_target = top + 1 (modulo 2^PC_W), stack unchanged.
REQ-021 RUN, ']' with acc_zero=1: SHALL pop, depth-1, no redirect.
REQ-022 SKIP: SHALL assert squash=1 for every valid instruction, never assert pc_load, and ignore acc_zero.
REQ-023 SKIP, '[': SHALL set nest = nest + 1.
REQ-024 SKIP, ']' with nest>0: SHALL set nest = nest - 1; with nest=0: SHALL return to RUN.
REQ-025 RUN, '[' with acc_zero=0 at depth=DEPTH (overflow): SHALL enter FAULT, no push.
REQ-026 RUN, ']' at depth=0 (underflow): SHALL enter FAULT, no redirect.
REQ-027 SKIP, '[' with nest = 2^NEST_W - 1: SHALL enter FAULT.
REQ-028 is_open and is_close both high with instr_valid: SHALL enter FAULT.
REQ-029 FAULT: SHALL hold fault=1, squash=1, pc_load=0; only reset or clear SHALL exit.
REQ-030 clear: SHALL set state RUN, depth 0, nest 0 on the next edge; clear SHALL win over a simultaneous valid instruction, which is ignored; squash=0 and pc_load=0 in that cycle.
REQ-031 Non-bracket instructions in RUN: SHALL produce no state change, squash=0, pc_load=0.
REQ-032 instr_valid=0: SHALL hold all state; pc_load=0, squash=0.

Reset
REQ-033 Asserting reset SHALL immediately force state RUN, depth 0, nest 0, fault 0, pc_load 0, squash 0, pc_target 0, regardless of clk, including mid-SKIP or mid-FAULT.
REQ-034 Stack storage contents SHALL need no reset; entries above depth are never observable.

Structure
REQ-035 The LOOP_STATE enum (RUN, SKIP, FAULT) and default PC_W/DEPTH/NEST_W constants SHALL live in the shared definitions package.
REQ-036 Return-address storage SHALL be a sub-module pc_lifo (parameters PC_W, DEPTH; push, pop, top, count) with no internal fault logic.

Verification
REQ-037 Bench SHALL cover: '[' at pc=5 (acc_zero=0), ']' at pc=9 (acc_zero=0) -> pc_load=1, pc_target=6, depth=1; repeat ']' with acc_zero=1 -> depth=0, no redirect.
REQ-038 Bench SHALL cover: '[' at pc=3 with acc_zero=1, then "[ ] ]" -> squash=1 on all four, nest 0->1->0, RUN after final ']', depth stays 0.
REQ-039 Bench SHALL cover: DEPTH=4, five '[' with acc_zero=0 -> depth=4, fault=1 after fifth; clear -> depth=0, fault=0.
REQ-040 Bench SHALL cover: ']' at depth=0 -> fault=1, pc_load=0; further '[' ignored with squash=1.
REQ-041 Bench SHALL cover: reset asserted between edges while in SKIP with nest=2 -> outputs zero immediately, RUN, depth=0 before the next edge.
REQ-042 Bench SHALL cover: clear and valid '[' (acc_zero=0) in the same cycle -> depth=0 after edge, no push.

Source files
------------

// File: rtl/loop_stack_unit_pkg.sv
// Shared definitions for the loop stack unit: state encoding, default
// geometry and a small decode helper.
package loop_stack_unit_pkg;

    localparam int DEF_PC_W   = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NEST_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SKIP  = 2'd1,
        FAULT = 2'd2
    } loop_state_t;

    // An instruction cannot be both brackets; treat that as a decode fault.
    function automatic logic bracket_conflict(input logic is_open, input logic is_close);
        return is_open & is_close;
    endfunction

endpackage

// File: rtl/loop_stack_unit_pc_lifo.sv
// Return-address LIFO. Plain storage with occupancy count.
// Callers must not push when full or pop when empty.
module pc_lifo #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PC_W-1:0]            push_data,
    output logic [PC_W-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0] mem_r [DEPTH];
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   top_idx_s;
    logic            full_s;
    logic            write_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign write_s   = push & ~flush & ~full_s;
    assign top_idx_s = count_r - CW'(1);
    assign count     = count_r;

    // Occupancy counter; flush empties the stack in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            count_r <= {CW{1'b0}};
        end else if (write_s) begin
            count_r <= count_r + CW'(1);
        end else if (pop && (count_r != {CW{1'b0}})) begin
            count_r <= count_r - CW'(1);
        end
    end

    // Storage array; contents above count are never read, so no reset.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[count_r[AW-1:0]] <= push_data;
        end
    end

    // Top-of-stack read; an empty stack reads as zero.
    always_comb begin
        top = {PC_W{1'b0}};
        if (count_r != {CW{1'b0}}) begin
            top = mem_r[top_idx_s[AW-1:0]];
        end else begin
            top = {PC_W{1'b0}};
        end
    end

endmodule

// File: rtl/loop_stack_unit.sv
// Bracket-loop control: tracks open loops on a return stack, redirects
// fetch on a taken ']', and squashes the body of a skipped loop.
module loop_stack_unit
    import loop_stack_unit_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NEST_W = DEF_NEST_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       instr_valid,
    input  logic                       is_open,
    input  logic                       is_close,
    input  logic [PC_W-1:0]            pc,
    input  logic                       acc_zero,
    input  logic                       clear,
    output logic                       pc_load,
    output logic [PC_W-1:0]            pc_target,
    output logic                       squash,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       fault
);
    localparam int CW = $clog2(DEPTH + 1);

    loop_state_t       state_r;
    loop_state_t       state_nxt_s;
    logic [NEST_W-1:0] nest_r;
    logic [NEST_W-1:0] nest_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic [PC_W-1:0]   top_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic              nest_max_s;

    assign full_s     = (count_s == CW'(DEPTH));
    assign empty_s    = (count_s == {CW{1'b0}});
    assign nest_max_s = (nest_r == {NEST_W{1'b1}});
    assign depth      = count_s;
    assign fault      = (state_r == FAULT);

    pc_lifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_pc_lifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc),
        .top       (top_s),
        .count     (count_s)
    );

    // State and skip-nesting registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
            nest_r  <= {NEST_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            nest_r  <= nest_nxt_s;
        end
    end

    // Next-state, nesting and stack control decode.
    always_comb begin
        state_nxt_s = state_r;
        nest_nxt_s  = nest_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (clear) begin
            state_nxt_s = RUN;
            nest_nxt_s  = {NEST_W{1'b0}};
        end else if (instr_valid) begin
            case (state_r)
                RUN: begin
                    if (bracket_conflict(is_open, is_close)) begin
                        state_nxt_s = FAULT;
                    end else if (is_open) begin
                        if (acc_zero) begin
                            state_nxt_s = SKIP;
                            nest_nxt_s  = {NEST_W{1'b0}};
                        end else if (full_s) begin
                            state_nxt_s = FAULT;
                        end else begin
                            push_s = 1'b1;
                        end
                    end else if (is_close) begin
                        if (empty_s) begin
                            state_nxt_s = FAULT;
                        end else if (acc_zero) begin
                            pop_s = 1'b1;
                        end else begin
                            pop_s = 1'b0;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                SKIP: begin
                    if (bracket_conflict(is_open, is_close)) begin
                        state_nxt_s = FAULT;
                    end else if (is_open) begin
                        if (nest_max_s) begin
                            state_nxt_s = FAULT;
                        end else begin
                            nest_nxt_s = nest_r + NEST_W'(1);
                        end
                    end else if (is_close) begin
                        if (nest_r == {NEST_W{1'b0}}) begin
                            state_nxt_s = RUN;
                        end else begin
                            nest_nxt_s = nest_r - NEST_W'(1);
                        end
                    end else begin
                        state_nxt_s = SKIP;
                    end
                end
                FAULT: begin
                    state_nxt_s = FAULT;
                end
                default: begin
                    state_nxt_s = FAULT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Zero-latency redirect and squash for the presented instruction.
    always_comb begin
        pc_load   = 1'b0;
        pc_target = {PC_W{1'b0}};
        squash    = 1'b0;
        if (reset || clear || !instr_valid) begin
            squash = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (bracket_conflict(is_open, is_close)) begin
                        squash = 1'b1;
                    end else if (is_open) begin
                        squash = acc_zero | full_s;
                    end else if (is_close) begin
                        if (empty_s) begin
                            squash = 1'b1;
                        end else if (!acc_zero) begin
                            pc_load   = 1'b1;
                            pc_target = top_s + PC_W'(1);
                        end else begin
                            squash = 1'b0;
                        end
                    end else begin
                        squash = 1'b0;
                    end
                end
                SKIP: begin
                    squash = 1'b1;
                end
                FAULT: begin
                    squash = 1'b1;
                end
                default: begin
                    squash = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_stack_unit.sv
// Directed bench for loop_stack_unit with hand-computed expectations.
module tb_loop_stack_unit;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        is_open;
    logic        is_close;
    logic [15:0] pc;
    logic        acc_zero;
    logic        clear;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        squash;
    logic [2:0]  depth;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    loop_stack_unit #(
        .PC_W   (16),
        .DEPTH  (4),
        .NEST_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .is_open     (is_open),
        .is_close    (is_close),
        .pc          (pc),
        .acc_zero    (acc_zero),
        .clear       (clear),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .squash      (squash),
        .depth       (depth),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction (or idle/clear) and let combinational outputs settle.
    task automatic present(input logic v, input logic o, input logic c,
                           input logic [15:0] p, input logic a, input logic clr);
        instr_valid = v;
        is_open     = o;
        is_close    = c;
        pc          = p;
        acc_zero    = a;
        clear       = clr;
        #1;
    endtask

    // Advance one rising edge, then return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        is_open     = 1'b0;
        is_close    = 1'b0;
        clear       = 1'b0;
        acc_zero    = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        instr_valid = 1'b0; is_open = 1'b0; is_close = 1'b0;
        pc = 16'd0; acc_zero = 1'b0; clear = 1'b0;
        #12;
        check_eq("rst_depth",   32'(depth), 32'd0);
        check_eq("rst_fault",   32'(fault), 32'd0);
        check_eq("rst_pc_load", 32'(pc_load), 32'd0);
        check_eq("rst_squash",  32'(squash), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Taken loop: '[' @5, ']' @9 redirects to 6, then falls through.
        present(1'b1, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0);
        check_eq("open_squash", 32'(squash), 32'd0);
        check_eq("open_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("open_depth", 32'(depth), 32'd1);
        present(1'b1, 1'b0, 1'b1, 16'd9, 1'b0, 1'b0);
        check_eq("close_pc_load", 32'(pc_load), 32'd1);
        check_eq("close_target", 32'(pc_target), 32'd6);
        tick();
        check_eq("close_depth", 32'(depth), 32'd1);
        present(1'b1, 1'b0, 1'b1, 16'd9, 1'b1, 1'b0);
        check_eq("exit_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("exit_depth", 32'(depth), 32'd0);

        // Skipped loop "[ [ ] ]" starting at pc=3.
        present(1'b1, 1'b1, 1'b0, 16'd3, 1'b1, 1'b0);
        check_eq("skip0_squash", 32'(squash), 32'd1);
        tick();
        present(1'b1, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0);
        check_eq("skip1_squash", 32'(squash), 32'd1);
        check_eq("skip1_pc_load", 32'(pc_load), 32'd0);
        tick();
        present(1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0);
        check_eq("skip2_squash", 32'(squash), 32'd1);
        check_eq("skip2_pc_load", 32'(pc_load), 32'd0);
        tick();
        present(1'b1, 1'b0, 1'b1, 16'd6, 1'b0, 1'b0);
        check_eq("skip3_squash", 32'(squash), 32'd1);
        tick();
        check_eq("skip_depth", 32'(depth), 32'd0);
        present(1'b1, 1'b0, 1'b0, 16'd7, 1'b0, 1'b0);
        check_eq("skip_back_run", 32'(squash), 32'd0);
        tick();

        // Nest counter saturation: with NEST_W=2 the fourth inner '[' faults.
        present(1'b1, 1'b1, 1'b0, 16'd20, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 1'b1, 1'b0, 16'(21 + i), 1'b0, 1'b0);
            tick();
        end
        check_eq("nest3_fault", 32'(fault), 32'd0);
        present(1'b1, 1'b1, 1'b0, 16'd24, 1'b0, 1'b0);
        tick();
        check_eq("nest_ovf_fault", 32'(fault), 32'd1);
        present(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();
        check_eq("nest_clr_fault", 32'(fault), 32'd0);

        // Overflow: DEPTH=4, fifth '[' faults without pushing.
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 1'b1, 1'b0, 16'(10 + i), 1'b0, 1'b0);
            tick();
        end
        check_eq("full_depth", 32'(depth), 32'd4);
        check_eq("full_fault", 32'(fault), 32'd0);
        present(1'b1, 1'b1, 1'b0, 16'd14, 1'b0, 1'b0);
        tick();
        check_eq("ovf_depth", 32'(depth), 32'd4);
        check_eq("ovf_fault", 32'(fault), 32'd1);
        present(1'b1, 1'b0, 1'b1, 16'd15, 1'b0, 1'b0);
        check_eq("ovf_hold_squash", 32'(squash), 32'd1);
        check_eq("ovf_hold_pc_load", 32'(pc_load), 32'd0);
        tick();
        present(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        check_eq("clr_squash", 32'(squash), 32'd0);
        check_eq("clr_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("clr_depth", 32'(depth), 32'd0);
        check_eq("clr_fault", 32'(fault), 32'd0);

        // Redirect target wraps modulo 2^16.
        present(1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0);
        check_eq("wrap_pc_load", 32'(pc_load), 32'd1);
        check_eq("wrap_target", 32'(pc_target), 32'd0);
        tick();
        // instr_valid low holds everything and drives nothing.
        present(1'b0, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0);
        check_eq("idle_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("idle_depth", 32'(depth), 32'd1);
        present(1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 1'b0);
        tick();
        check_eq("wrap_pop_depth", 32'(depth), 32'd0);

        // Underflow: ']' at depth 0 faults; later '[' is squashed and ignored.
        present(1'b1, 1'b0, 1'b1, 16'd30, 1'b0, 1'b0);
        check_eq("unf_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("unf_fault", 32'(fault), 32'd1);
        present(1'b1, 1'b1, 1'b0, 16'd31, 1'b0, 1'b0);
        check_eq("unf_open_squash", 32'(squash), 32'd1);
        tick();
        check_eq("unf_open_depth", 32'(depth), 32'd0);
        check_eq("unf_still_fault", 32'(fault), 32'd1);
        present(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();

        // Both bracket flags at once is a decode fault.
        present(1'b1, 1'b1, 1'b1, 16'd40, 1'b0, 1'b0);
        tick();
        check_eq("both_fault", 32'(fault), 32'd1);
        present(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1);
        tick();

        // Async reset mid-cycle while in SKIP with nest=2 and one open loop.
        present(1'b1, 1'b1, 1'b0, 16'd50, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b1, 1'b0, 16'd51, 1'b1, 1'b0);
        tick();
        present(1'b1, 1'b1, 1'b0, 16'd52, 1'b0, 1'b0);
        tick();
        present(1'b1, 1'b1, 1'b0, 16'd53, 1'b0, 1'b0);
        tick();
        check_eq("pre_rst_depth", 32'(depth), 32'd1);
        present(1'b1, 1'b0, 1'b1, 16'd54, 1'b0, 1'b0);
        check_eq("pre_rst_squash", 32'(squash), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("arst_squash", 32'(squash), 32'd0);
        check_eq("arst_pc_load", 32'(pc_load), 32'd0);
        check_eq("arst_target", 32'(pc_target), 32'd0);
        check_eq("arst_depth", 32'(depth), 32'd0);
        check_eq("arst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        instr_valid = 1'b0;
        #1;
        present(1'b1, 1'b0, 1'b0, 16'd55, 1'b0, 1'b0);
        check_eq("arst_run", 32'(squash), 32'd0);
        tick();

        // Clear beats a simultaneous '[': stack empties, nothing pushed.
        present(1'b1, 1'b1, 1'b0, 16'd60, 1'b0, 1'b0);
        tick();
        check_eq("pre_clr_depth", 32'(depth), 32'd1);
        present(1'b1, 1'b1, 1'b0, 16'd7, 1'b0, 1'b1);
        check_eq("clr_open_squash", 32'(squash), 32'd0);
        check_eq("clr_open_pc_load", 32'(pc_load), 32'd0);
        tick();
        check_eq("clr_open_depth", 32'(depth), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
